// File: rtl/gate_truth_checker.sv
// gate_truth_checker: clocked stimulus/response checker for a 2-input gate.
// It walks {m,n} through 00, 01, 10, 11. Each vector is held for SETTLE cycles.
// The gate output p is sampled on the last cycle of each vector and compared
// against EXP_TT[{m,n}]. The result is reported as a pass flag plus a
// per-vector error mask.
// Optional feature macro: GATE_CHK_FAILCNT_EN adds an 8-bit saturating count
// of failed runs (fail_cnt), which is cleared only by rst_n.
module gate_truth_checker #(
    parameter logic [3:0] EXP_TT = 4'b0111,  // bit k = expected p for {m,n} = k
    parameter int         SETTLE = 2         // cycles per vector, legal 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       m,
    output logic       n,
    input  logic       p,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask
`ifdef GATE_CHK_FAILCNT_EN
    ,
    output logic [7:0] fail_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Last settle-counter value of a vector; the edge at this count samples p.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q;
    logic [1:0] vec_q;
    logic [3:0] cnt_q;
    logic       m_q;
    logic       n_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] err_mask_q;

    logic [3:0] err_mask_d;
    logic [1:0] vec_d;

`ifdef GATE_CHK_FAILCNT_EN
    logic [7:0] fail_cnt_q;
`endif

    // Error mask as it will look after sampling the current vector.
    always_comb begin
        err_mask_d        = err_mask_q;
        err_mask_d[vec_q] = (p != EXP_TT[vec_q]);
        vec_d             = vec_q + 2'd1;
    end

    // Run sequencer. All outputs are registered, and reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= 2'd0;
            cnt_q      <= 4'd0;
            m_q        <= 1'b0;
            n_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_mask_q <= 4'b0000;
`ifdef GATE_CHK_FAILCNT_EN
            fail_cnt_q <= 8'd0;
`endif
        end else begin
            // done is a single-cycle pulse; only the RUN->FIN transition raises it
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    m_q    <= 1'b0;
                    n_q    <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q    <= ST_RUN;
                        vec_q      <= 2'd0;
                        cnt_q      <= 4'd0;
                        err_mask_q <= 4'b0000;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == SETTLE_LAST) begin
                        err_mask_q <= err_mask_d;
                        if (vec_q == 2'd3) begin
                            // The vector index never wraps; the run ends after 11
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            m_q     <= 1'b0;
                            n_q     <= 1'b0;
                            pass_q  <= (err_mask_d == 4'b0000);
                        end else begin
                            // The next vector goes out on the same edge that samples the current one
                            vec_q <= vec_d;
                            cnt_q <= 4'd0;
                            m_q   <= vec_d[1];
                            n_q   <= vec_d[0];
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_FIN: begin
                    // A start request in this cycle is dropped; there is no queuing
                    state_q <= ST_IDLE;
`ifdef GATE_CHK_FAILCNT_EN
                    if (!pass_q && (fail_cnt_q != 8'hFF)) begin
                        fail_cnt_q <= fail_cnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m        = m_q;
    assign n        = n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_mask = err_mask_q;
`ifdef GATE_CHK_FAILCNT_EN
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Sequential stimulus/response engine for 2-input combinational gate modules (structural NAND and its siblings). It sits on the other end of a gate's pins: it drives `m`/`n` through all four input combinations and samples the gate output `p`. It compares each sample against a parameterised truth table and reports pass/fail plus a per-vector error mask. It replaces hand-written `#5` stimulus benches with a clocked, self-checking block usable in simulation or on a board.

## Interface
Parameters:
- `EXP_TT`, 4'b0111, expected truth table; bit k = expected `p` for vector k = {m,n} (default = NAND)
- `SETTLE`, 2, cycles each vector is held before `p` is sampled; legal range 1..15

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a check run; honoured only in IDLE
- `m`  out  1  gate input A (registered)
- `n`  out  1  gate input B (registered)
- `p`  in  1  gate output under test; treated as synchronous, sampled only at sample edges
- `busy`  out  1  high while a run is in progress
- `done`  out  1  one-cycle pulse when a run completes
- `pass`  out  1  1 = last run had no mismatches; held until next accepted start
- `err_mask`  out  4  bit k set = vector k mismatched; held until next accepted start

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: `m`=`n`=0, `busy`=0. When `start`=1 at a rising edge, go to RUN: vec←0, settle counter←0, `err_mask`←0, `pass`←0, `busy`←1.
- RUN: `{m,n}` = vec. The settle counter counts 0..SETTLE-1. At the edge where the counter = SETTLE-1, this is the sample edge:
  - `err_mask[vec]` ← (`p` != `EXP_TT[vec]`)
  - if vec = 3, go to FIN; else vec←vec+1 and counter←0
- FIN (one cycle): `done`=1, `busy`=0, `m`=`n`=0, `pass` = (`err_mask`==0). Next edge returns to IDLE.
- Vector order is fixed: 00, 01, 10, 11. The vector index does not wrap; the run ends after vector 3.
- `start` during RUN or FIN is ignored. No queuing.
- Reset values: `m`=0, `n`=0, `busy`=0, `done`=0, `pass`=0, `err_mask`=4'b0000, state IDLE.
- Reset asserted mid-run: all outputs go to reset values immediately (asynchronously). Partial results are discarded and `done` does not pulse.

## Timing
- E0 = the edge that accepts `start`.
- Vector k is driven from edge E0+k·SETTLE.
- Vector k is sampled at edge E0+(k+1)·SETTLE. The next vector is applied on that same edge.
- `done`/`pass` are visible in the cycle after edge E0+4·SETTLE. `done` falls at edge E0+4·SETTLE+1.
- Run latency, start-accept to `done` high, is 4·SETTLE cycles. With SETTLE=2 this is 8 cycles.
- `start` high in the FIN cycle is not accepted. The earliest re-accept is the edge after returning to IDLE.
- `p` must be stable for the hold/setup window around each sample edge. The DUT is combinational, so SETTLE ≥ 1 suffices in simulation.

## Configuration
- Macro: `GATE_CHK_FAILCNT_EN`.
- Defined: adds output `fail_cnt` [7:0].
  - Increments by 1 in each FIN cycle where `pass`=0.
  - Saturates at 255.
  - Cleared only by `rst_n`; persists across runs.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Correct NAND DUT, EXP_TT=4'b0111, SETTLE=2. Pulse `start` at E0. Expect:
  - `{m,n}` steps 00, 01, 10, 11 at E0, E0+2, E0+4, E0+6
  - `done`=1 after E0+8
  - `pass`=1, `err_mask`=4'b0000
- `p` tied 0, default EXP_TT. Expect `err_mask`=4'b0111, `pass`=0.
- AND DUT connected, default EXP_TT. Expect `err_mask`=4'b1111, `pass`=0. Then EXP_TT=4'b1000, rerun: expect `pass`=1.
- Re-pulse `start` at E0+3 during RUN. Expect it to be ignored: still exactly one `done`, at E0+8. Re-pulse `start` in the FIN cycle. Expect no new run.
- Assert `rst_n`=0 at E0+5. Expect:
  - `m`,`n`,`busy`,`pass`,`err_mask` go to 0 immediately
  - no `done` pulse
  - a fresh `start` after release runs a full 8-cycle check
- With `GATE_CHK_FAILCNT_EN`, `p` tied 0: run 3 times and expect `fail_cnt`=3. Then run with a correct DUT and expect `fail_cnt` stays 3. Assert reset and expect `fail_cnt`=0.
